transport_receive: RTL and testbench
====================================

Name: transport_receive

Overview:
Receive-side transport stage. Consumes the fixed-length byte packets produced by the send-side transport stage and recovers the typed 16-bit words from them. It parses the header byte, extracts control or audio words, and checks padding and trailer. Recovered words go out through a small valid/ready output FIFO to the control and audio consumers.

Parameters:
PACKET_SIZE, 16, bytes per packet including header; must be even and >= 4
FIFO_DEPTH, 4, output word FIFO entries; power of two
GAP_TIMEOUT, 64, idle cycles mid-packet before the packet is aborted

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (asserted at 0)
byte_valid  input  1  byte_in valid this cycle (driven from sender's sending strobe)
byte_in  input  8  packet byte stream, header first
out_valid  output  1  FIFO head holds a word
out_ready  input  1  consumer accepts head word this cycle
out_cmd  output  2  word type: 2'b01 control, 2'b10 audio (never 00 while out_valid)
out_data  output  16  recovered word, big-endian reassembled {hi,lo}
busy  output  1  high while a packet is partially received
pkt_done  output  1  one-cycle pulse when the last byte of a well-formed packet is accepted
pkt_error  output  1  one-cycle pulse on a bad header, bad trailer or gap timeout
overflow  output  1  sticky; set when a word is dropped because the FIFO is full; cleared only by reset

Behaviour:
- Reset (reset==0, async): state IDLE; byte counter, gap counter, and FIFO pointers/count all 0. All outputs 0.
- Bytes are consumed only on cycles where byte_valid==1. byte_in is ignored when byte_valid==0.
- Byte counter bcnt counts accepted bytes in the current packet. The packet ends when the byte with bcnt==PACKET_SIZE-1 is accepted. The machine then returns to IDLE and bcnt goes to 0.
- FSM states: IDLE, CTRL_HI, CTRL_LO, PAD, AUD_HI, AUD_LO, TRAILER, DISCARD.
- IDLE:
  - byte 8'h40 -> CTRL_HI.
  - byte 8'h80 -> AUD_HI.
  - any other byte -> DISCARD, with a pkt_error pulse.
- Control packet:
  - CTRL_HI latches the high byte.
  - CTRL_LO pushes {01, hi, lo} and moves to PAD.
  - PAD accepts PACKET_SIZE-3 bytes. Nonzero padding bytes are ignored, not an error.
- Audio packet:
  - AUD_HI/AUD_LO alternate and push {10, hi, lo} on each AUD_LO. That gives (PACKET_SIZE-2)/2 words per packet.
  - After the last AUD_LO the FSM moves to TRAILER.
  - TRAILER byte must be 8'hFF. Any other value gives a pkt_error pulse instead of pkt_done. Words already pushed are not retracted.
- DISCARD: swallows bytes until bcnt reaches PACKET_SIZE-1, then goes to IDLE. No pkt_done for a discarded packet.
- busy = (state != IDLE).
- Gap timeout:
  - The gap counter increments on each cycle that is not IDLE and has byte_valid==0, and clears on byte_valid==1.
  - When it reaches GAP_TIMEOUT the FSM goes to IDLE, pkt_error pulses and bcnt clears.
- FIFO push latency:
  - A word whose low byte is sampled at edge k is visible at the head at edge k+1 if the FIFO was empty (out_valid=1 after edge k+1).
  - out_cmd and out_data are registered from the FIFO head.
- Handshake:
  - A pop happens when out_valid && out_ready.
  - out_data and out_cmd must stay stable while out_valid && !out_ready.
- Full/empty:
  - A push when count==FIFO_DEPTH with no simultaneous pop drops the word and sets overflow.
  - Simultaneous push and pop when full: both happen, the word is accepted and count is unchanged.
  - A pop when empty is impossible, because out_valid==0.
- Pointers wrap modulo FIFO_DEPTH. count is log2(FIFO_DEPTH)+1 bits wide.
- Reset mid-packet: all state is lost and the next byte is treated as a header.

Optional Feature:
TRANSPORT_RCV_STATS_EN.
- When defined, three extra outputs are added:
  - good_pkts[15:0]: increments on pkt_done.
  - err_pkts[15:0]: increments on pkt_error.
  - drop_words[15:0]: increments per dropped word.
- The counters saturate at 16'hFFFF and clear on reset.
- When undefined, these ports and their logic do not exist and the behaviour is otherwise identical.

Test Plan:
- Control packet: bytes 40,12,34 then 13×00, contiguous, out_ready=1 -> one word out_cmd=01, out_data=16'h1234. pkt_done pulses on the 16th byte. busy drops the next cycle.
- Audio packet: 80, then bytes 01..0E, then FF -> seven audio words 0102, 0304, …, 0D0E in order, then pkt_done.
- Audio packet ending in EE instead of FF -> same 7 words, then pkt_error pulse and no pkt_done. A following valid control packet is decoded correctly.
- Header 8'h55 followed by 15 bytes -> pkt_error on the first byte, no words out, next packet decoded normally.
- out_ready held 0 during an audio packet with FIFO_DEPTH=4 -> the first 4 words are held stable and words 5–7 are dropped, overflow=1. Releasing out_ready drains 0102, 0304, 0506, 0708.
- Header 80 plus 3 bytes, then byte_valid low for 64 cycles -> pkt_error at the timeout and busy=0. Asserting reset (0) mid-packet clears everything asynchronously.

Source files
------------

// File: rtl/transport_receive.sv
// transport_receive: receive-side transport stage.
//
// Parses fixed-length byte packets (header byte first) and recovers typed
// 16-bit words. A 0x40 header carries one control word followed by padding.
// A 0x80 header carries (PacketSize-2)/2 audio words followed by a 0xFF
// trailer. Any other header discards the packet. Recovered words leave
// through a small valid/ready FIFO.
//
// Ports:
//   clk_i         system clock
//   rst_ni        asynchronous active-low reset
//   byte_valid_i  byte_in_i is valid this cycle
//   byte_in_i     packet byte stream, header first
//   out_valid_o   FIFO head holds a word
//   out_ready_i   consumer accepts the head word this cycle
//   out_cmd_o     word type: 2'b01 control, 2'b10 audio
//   out_data_o    recovered word {hi, lo}
//   busy_o        a packet is partially received
//   pkt_done_o    one-cycle pulse after the last byte of a good packet
//   pkt_error_o   one-cycle pulse on bad header, bad trailer or gap timeout
//   overflow_o    sticky, set when a word is dropped on a full FIFO
//
// Optional build macro TRANSPORT_RCV_STATS_EN adds saturating counters:
//   good_pkts_o, err_pkts_o, drop_words_o.
module transport_receive #(
  parameter int unsigned PacketSize = 16,
  parameter int unsigned FifoDepth  = 4,
  parameter int unsigned GapTimeout = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_in_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [1:0]  out_cmd_o,
  output logic [15:0] out_data_o,
  output logic        busy_o,
  output logic        pkt_done_o,
  output logic        pkt_error_o,
  output logic        overflow_o
`ifdef TRANSPORT_RCV_STATS_EN
  ,
  output logic [15:0] good_pkts_o,
  output logic [15:0] err_pkts_o,
  output logic [15:0] drop_words_o
`endif
);

  localparam int unsigned BcntW = $clog2(PacketSize);
  localparam int unsigned GapW  = $clog2(GapTimeout + 1);
  localparam int unsigned PtrW  = $clog2(FifoDepth);
  localparam int unsigned CntW  = PtrW + 1;

  localparam logic [7:0] HdrCtrl = 8'h40;
  localparam logic [7:0] HdrAud  = 8'h80;
  localparam logic [7:0] Trailer = 8'hFF;
  localparam logic [1:0] CmdCtrl = 2'b01;
  localparam logic [1:0] CmdAud  = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StCtrlHi,
    StCtrlLo,
    StPad,
    StAudHi,
    StAudLo,
    StTrailer,
    StDiscard
  } state_e;

  state_e            state_q;
  logic [BcntW-1:0]  bcnt_q;
  logic [GapW-1:0]   gap_q;
  logic [7:0]        hi_q;
  logic              pkt_done_q;
  logic              pkt_error_q;

  // Recovered words are staged for one cycle before entering the FIFO.
  logic              push_vld_q;
  logic [17:0]       push_word_q;

  logic              last_byte;
  logic              last_aud_lo;

  assign last_byte   = (bcnt_q == BcntW'(PacketSize - 1));
  assign last_aud_lo = (bcnt_q == BcntW'(PacketSize - 2));

  // Packet parser
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      bcnt_q      <= '0;
      gap_q       <= '0;
      hi_q        <= '0;
      pkt_done_q  <= 1'b0;
      pkt_error_q <= 1'b0;
      push_vld_q  <= 1'b0;
      push_word_q <= '0;
    end else begin
      pkt_done_q  <= 1'b0;
      pkt_error_q <= 1'b0;
      push_vld_q  <= 1'b0;
      if (byte_valid_i) begin
        gap_q  <= '0;
        bcnt_q <= last_byte ? '0 : bcnt_q + BcntW'(1);
        unique case (state_q)
          StIdle: begin
            if (byte_in_i == HdrCtrl) begin
              state_q <= StCtrlHi;
            end else if (byte_in_i == HdrAud) begin
              state_q <= StAudHi;
            end else begin
              state_q     <= StDiscard;
              pkt_error_q <= 1'b1;
            end
          end
          StCtrlHi: begin
            hi_q    <= byte_in_i;
            state_q <= StCtrlLo;
          end
          StCtrlLo: begin
            push_vld_q  <= 1'b1;
            push_word_q <= {CmdCtrl, hi_q, byte_in_i};
            state_q     <= StPad;
          end
          StPad: begin
            // Padding content is not checked.
            if (last_byte) begin
              state_q    <= StIdle;
              pkt_done_q <= 1'b1;
            end
          end
          StAudHi: begin
            hi_q    <= byte_in_i;
            state_q <= StAudLo;
          end
          StAudLo: begin
            push_vld_q  <= 1'b1;
            push_word_q <= {CmdAud, hi_q, byte_in_i};
            state_q     <= last_aud_lo ? StTrailer : StAudHi;
          end
          StTrailer: begin
            // Audio words already pushed stay in the FIFO on a bad trailer.
            state_q <= StIdle;
            if (byte_in_i == Trailer) begin
              pkt_done_q <= 1'b1;
            end else begin
              pkt_error_q <= 1'b1;
            end
          end
          StDiscard: begin
            if (last_byte) begin
              state_q <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end else if (state_q != StIdle) begin
        if (gap_q == GapW'(GapTimeout - 1)) begin
          state_q     <= StIdle;
          bcnt_q      <= '0;
          gap_q       <= '0;
          pkt_error_q <= 1'b1;
        end else begin
          gap_q <= gap_q + GapW'(1);
        end
      end
    end
  end

  // Output FIFO
  logic [17:0]     mem_q [FifoDepth];
  logic [PtrW-1:0] wptr_q;
  logic [PtrW-1:0] rptr_q;
  logic [CntW-1:0] count_q;
  logic            overflow_q;
  logic            fifo_full;
  logic            pop;
  logic            do_push;
  logic            drop;

  assign fifo_full = (count_q == CntW'(FifoDepth));
  assign pop       = out_valid_o && out_ready_i;
  // When full, a simultaneous pop frees the slot being written.
  assign do_push   = push_vld_q && (!fifo_full || pop);
  assign drop      = push_vld_q && fifo_full && !pop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) begin
        wptr_q <= wptr_q + PtrW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      unique case ({do_push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q] <= push_word_q;
    end
  end

  assign out_valid_o = (count_q != '0);
  assign out_cmd_o   = out_valid_o ? mem_q[rptr_q][17:16] : 2'b00;
  assign out_data_o  = out_valid_o ? mem_q[rptr_q][15:0] : 16'h0000;
  assign busy_o      = (state_q != StIdle);
  assign pkt_done_o  = pkt_done_q;
  assign pkt_error_o = pkt_error_q;
  assign overflow_o  = overflow_q;

`ifdef TRANSPORT_RCV_STATS_EN
  logic [15:0] good_q;
  logic [15:0] err_q;
  logic [15:0] drop_q;

  // Packet counters follow their pulse by one cycle; drops count on the dropping edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      good_q <= '0;
      err_q  <= '0;
      drop_q <= '0;
    end else begin
      if (pkt_done_q && (good_q != 16'hFFFF)) begin
        good_q <= good_q + 16'd1;
      end
      if (pkt_error_q && (err_q != 16'hFFFF)) begin
        err_q <= err_q + 16'd1;
      end
      if (drop && (drop_q != 16'hFFFF)) begin
        drop_q <= drop_q + 16'd1;
      end
    end
  end

  assign good_pkts_o  = good_q;
  assign err_pkts_o   = err_q;
  assign drop_words_o = drop_q;
`endif

endmodule

// File: tb/tb_transport_receive.sv
// Testbench for transport_receive: directed packets plus randomized packet
// streams, checked against a byte-position reference model of the protocol.
module tb_transport_receive;

  localparam int PACKET_SIZE = 16;
  localparam int FIFO_DEPTH  = 4;
  localparam int GAP_TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  out_cmd;
  logic [15:0] out_data;
  logic        busy;
  logic        pkt_done;
  logic        pkt_error;
  logic        overflow;
`ifdef TRANSPORT_RCV_STATS_EN
  logic [15:0] good_pkts;
  logic [15:0] err_pkts;
  logic [15:0] drop_words;
`endif

  always #5 clk = ~clk;

  transport_receive #(
    .PacketSize (PACKET_SIZE),
    .FifoDepth  (FIFO_DEPTH),
    .GapTimeout (GAP_TIMEOUT)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .byte_valid_i (byte_valid),
    .byte_in_i    (byte_in),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_cmd_o    (out_cmd),
    .out_data_o   (out_data),
    .busy_o       (busy),
    .pkt_done_o   (pkt_done),
    .pkt_error_o  (pkt_error),
`ifdef TRANSPORT_RCV_STATS_EN
    .good_pkts_o  (good_pkts),
    .err_pkts_o   (err_pkts),
    .drop_words_o (drop_words),
`endif
    .overflow_o   (overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: packet position, packet kind, word queue.
  int          m_pos;
  int          m_kind;  // 0 control, 1 audio, 2 bad header
  logic [7:0]  m_hi;
  int          m_gap;
  bit          m_in_pkt;
  logic [17:0] m_fifo[$];
  bit          m_pend_v;
  logic [17:0] m_pend;
  bit          m_ovf;
  bit          m_done;
  bit          m_err;
  int          m_good;
  int          m_errs;
  int          m_drops;

  logic [7:0]  pkt_buf [PACKET_SIZE];

  task automatic model_reset();
    m_pos = 0; m_kind = 0; m_hi = 8'h00; m_gap = 0; m_in_pkt = 0;
    m_fifo.delete();
    m_pend_v = 0; m_pend = '0; m_ovf = 0; m_done = 0; m_err = 0;
    m_good = 0; m_errs = 0; m_drops = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    m_gap = 0;
    if (m_pos == 0) begin
      m_in_pkt = 1;
      if (b == 8'h40) m_kind = 0;
      else if (b == 8'h80) m_kind = 1;
      else begin
        m_kind = 2;
        m_err  = 1;
      end
    end else if (m_kind == 0) begin
      if (m_pos == 1) m_hi = b;
      else if (m_pos == 2) begin
        m_pend = {2'b01, m_hi, b};
        m_pend_v = 1;
      end
      if (m_pos == PACKET_SIZE - 1) m_done = 1;
    end else if (m_kind == 1) begin
      if (m_pos == PACKET_SIZE - 1) begin
        if (b == 8'hFF) m_done = 1;
        else m_err = 1;
      end else if (m_pos % 2 == 1) begin
        m_hi = b;
      end else begin
        m_pend = {2'b10, m_hi, b};
        m_pend_v = 1;
      end
    end
    m_pos++;
    if (m_pos == PACKET_SIZE) begin
      m_pos = 0;
      m_in_pkt = 0;
    end
  endtask

  task automatic compare_outputs();
    check("busy", 32'(busy), 32'(m_in_pkt));
    check("pkt_done", 32'(pkt_done), 32'(m_done));
    check("pkt_error", 32'(pkt_error), 32'(m_err));
    check("out_valid", 32'(out_valid), 32'(m_fifo.size() != 0));
    check("overflow", 32'(overflow), 32'(m_ovf));
    if (m_fifo.size() != 0) begin
      check("out_word", {14'b0, out_cmd, out_data}, 32'(m_fifo[0]));
    end
`ifdef TRANSPORT_RCV_STATS_EN
    check("good_pkts", 32'(good_pkts), 32'(m_good));
    check("err_pkts", 32'(err_pkts), 32'(m_errs));
    check("drop_words", 32'(drop_words), 32'(m_drops));
`endif
  endtask

  // One clock: drive inputs, advance model across the edge, compare after it.
  task automatic step(input logic v, input logic [7:0] b, input logic rdy);
    bit pop;
    byte_valid = v;
    byte_in    = v ? b : 8'($urandom);
    out_ready  = rdy;
    pop = (m_fifo.size() != 0) && rdy;
    @(posedge clk);
    #1;
    if (m_done) m_good++;
    if (m_err) m_errs++;
    m_done = 0;
    m_err  = 0;
    if (pop) void'(m_fifo.pop_front());
    if (m_pend_v) begin
      if (m_fifo.size() < FIFO_DEPTH) m_fifo.push_back(m_pend);
      else begin
        m_ovf = 1;
        m_drops++;
      end
    end
    m_pend_v = 0;
    if (v) begin
      model_byte(b);
    end else if (m_in_pkt) begin
      m_gap++;
      if (m_gap == GAP_TIMEOUT) begin
        m_in_pkt = 0;
        m_pos = 0;
        m_gap = 0;
        m_err = 1;
      end
    end
    compare_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1);
  endtask

  function automatic logic rdy_val(input int mode);
    if (mode == 0) return 1'b1;
    if (mode == 1) return 1'($urandom_range(0, 1));
    return ($urandom_range(0, 3) == 0);
  endfunction

  // Sends pkt_buf; gap_mode enables random idle cycles (rarely a timeout).
  task automatic send_pkt(input bit gap_mode, input int rmode);
    for (int i = 0; i < PACKET_SIZE; i++) begin
      if (gap_mode && i > 0) begin
        int g;
        g = int'($urandom_range(0, 59));
        if (g == 0) begin
          for (int k = 0; k < GAP_TIMEOUT + 3; k++) step(1'b0, 8'h00, rdy_val(rmode));
        end else if (g < 10) begin
          for (int k = 0; k < g % 4; k++) step(1'b0, 8'h00, rdy_val(rmode));
        end
      end
      step(1'b1, pkt_buf[i], rdy_val(rmode));
    end
  endtask

  task automatic fill_ctrl(input logic [7:0] hi, input logic [7:0] lo);
    pkt_buf[0] = 8'h40;
    pkt_buf[1] = hi;
    pkt_buf[2] = lo;
    for (int i = 3; i < PACKET_SIZE; i++) pkt_buf[i] = 8'h00;
  endtask

  task automatic fill_aud(input logic [7:0] trailer);
    pkt_buf[0] = 8'h80;
    for (int i = 1; i < PACKET_SIZE - 1; i++) pkt_buf[i] = 8'(i);
    pkt_buf[PACKET_SIZE-1] = trailer;
  endtask

  initial begin
    model_reset();
    // Reset state
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_cmd", 32'(out_cmd), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_done_err", {30'b0, pkt_done, pkt_error}, 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Control packet 40 12 34 + padding
    fill_ctrl(8'h12, 8'h34);
    send_pkt(1'b0, 0);
    idle(3);

    // Audio packet with good trailer, then with bad trailer and a control packet
    fill_aud(8'hFF);
    send_pkt(1'b0, 0);
    idle(3);
    fill_aud(8'hEE);
    send_pkt(1'b0, 0);
    fill_ctrl(8'hBE, 8'hEF);
    send_pkt(1'b0, 0);
    idle(3);

    // Bad header, then a normal packet
    pkt_buf[0] = 8'h55;
    for (int i = 1; i < PACKET_SIZE; i++) pkt_buf[i] = 8'h40;
    send_pkt(1'b0, 0);
    fill_ctrl(8'hA5, 8'h5A);
    send_pkt(1'b0, 0);
    idle(3);

    // Stalled consumer: four words held, three dropped, then drained
    fill_aud(8'hFF);
    for (int i = 0; i < PACKET_SIZE; i++) step(1'b1, pkt_buf[i], 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0);
    check("ovf_sticky", 32'(overflow), 32'd1);
    check("ovf_head", {14'b0, out_cmd, out_data}, 32'h2_0102);
    idle(6);

    // Gap timeout mid-packet
    step(1'b1, 8'h80, 1'b1);
    step(1'b1, 8'h01, 1'b1);
    step(1'b1, 8'h02, 1'b1);
    step(1'b1, 8'h03, 1'b1);
    idle(GAP_TIMEOUT + 2);
    check("timeout_busy", 32'(busy), 32'd0);

    // Asynchronous reset mid-packet with words queued and overflow set
    step(1'b1, 8'h80, 1'b0);
    for (int i = 1; i < 6; i++) step(1'b1, 8'(i), 1'b0);
    byte_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_overflow", 32'(overflow), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fill_ctrl(8'h77, 8'h88);
    send_pkt(1'b0, 0);
    idle(3);

    // Randomized packet stream
    for (int p = 0; p < 40; p++) begin
      int kind;
      int rmode;
      kind  = int'($urandom_range(0, 9));
      rmode = int'($urandom_range(0, 2));
      for (int i = 1; i < PACKET_SIZE; i++) pkt_buf[i] = 8'($urandom);
      if (kind == 0) begin
        do pkt_buf[0] = 8'($urandom); while (pkt_buf[0] == 8'h40 || pkt_buf[0] == 8'h80);
      end else if (kind < 5) begin
        pkt_buf[0] = 8'h40;
      end else begin
        pkt_buf[0] = 8'h80;
        if ($urandom_range(0, 4) != 0) pkt_buf[PACKET_SIZE-1] = 8'hFF;
      end
      send_pkt(1'b1, rmode);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 5)));
    end
    idle(8);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
